// File: rtl/twiddle_seq.sv
// twiddle_seq: streaming twiddle-factor source for the radix-2 DIF FFT.
// Emits W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) as packed {Tr, Ti} (Q2.10)
// in DIF stage order, from a quarter-wave cosine table with quadrant folding.
// inv = 1 emits conjugates for the IFFT.
//
// The quarter-wave table holds the same values as the ROM_FILE image
// (round(2^(DW-2) * cos(2*pi*i/N)), i = 0..N/4). It is computed at
// elaboration, so the block does not depend on an external image file.
//
// Optional build macro TWIDDLE_SEQ_IDX_OUT_EN: adds out_k, the exponent of the
// word on out_tw, pipelined in lockstep with out_tw.
module twiddle_seq #(
  parameter int    LOG2N    = 10,
  parameter int    DW       = 12,
  parameter string ROM_FILE = "complex_mult/cos_q.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        stage,
  input  logic              inv,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2*DW-1:0]   out_tw,
  output logic              out_last,
  output logic              busy,
  output logic              stage_err
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
  ,
  output logic [LOG2N-2:0]  out_k
`endif
);

  localparam int N  = 1 << LOG2N;
  localparam int HN = N / 2;
  localparam int QN = N / 4;
  localparam int KW = LOG2N - 1;   // exponent width, k in [0, N/2)
  localparam int AW = LOG2N - 1;   // table address width, addr in [0, N/4]

  // Fixed-point cosine for table generation: Q30 Taylor series on [0, pi/2],
  // rounded to nearest into Q(DW-2).
  function automatic logic [DW-1:0] cos_entry(input int i);
    longint pi_q, th, th2, term, sum, r;
    pi_q = 64'sd3373259426;                    // pi * 2^30
    th   = (pi_q * longint'(i)) >>> (LOG2N - 1); // 2*pi*i/N
    th2  = (th * th) >>> 30;
    term = longint'(1) <<< 30;
    sum  = term;
    for (int n = 1; n <= 14; n++) begin
      term = -((term * th2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    r = ((sum <<< (DW - 2)) + (longint'(1) <<< 29)) >>> 30;
    if (r < 0) r = 0;
    return DW'(r);
  endfunction

  // Quarter-wave table, read twice per word (real and imaginary ports).
  logic [DW-1:0] rom [0:QN];
  for (genvar i = 0; i <= QN; i++) begin : g_rom
    localparam logic [DW-1:0] COS_V = cos_entry(i);
    assign rom[i] = COS_V;
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [3:0]       s_q;
  logic             inv_q;
  logic [LOG2N-1:0] j, g;
  logic             en;

  // stage-1 registers
  logic             s1_vld, s1_last, s1_rneg, s1_ineg;
  logic [AW-1:0]    s1_ar, s1_ai;
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
  logic [KW-1:0]    s1_k;
`endif

  assign en = !out_valid || out_ready;

  // Loop bounds for the latched stage: span = N >> (s+1), 2^s groups.
  logic [LOG2N-1:0] span_m1, g_max;
  logic [KW-1:0]    k;
  logic             is_last;

  assign span_m1 = LOG2N'((N >> (int'(s_q) + 1)) - 1);
  assign g_max   = LOG2N'((1 << s_q) - 1);
  assign k       = KW'(j << s_q);
  assign is_last = (j == span_m1) && (g == g_max);

  // Quadrant fold of k into two table addresses plus negate flags.
  logic [AW-1:0] f_ar, f_ai;
  logic          f_rneg, f_ineg;

  always_comb begin
    f_ar   = k;
    f_ai   = AW'(QN) - k;
    f_rneg = 1'b0;
    f_ineg = !inv_q;
    if (k > KW'(QN)) begin
      f_ar   = AW'(HN - int'(k));
      f_ai   = k - AW'(QN);
      f_rneg = 1'b1;
    end
  end

  // Control FSM, span/group counters and stage-1 address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      inv_q     <= 1'b0;
      j         <= '0;
      g         <= '0;
      busy      <= 1'b0;
      stage_err <= 1'b0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_rneg   <= 1'b0;
      s1_ineg   <= 1'b0;
      s1_ar     <= '0;
      s1_ai     <= '0;
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
      s1_k      <= '0;
`endif
    end else begin
      stage_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (int'(stage) < LOG2N) begin
              state <= RUN;
              s_q   <= stage;
              inv_q <= inv;
              j     <= '0;
              g     <= '0;
              busy  <= 1'b1;
            end else begin
              stage_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (j == span_m1) begin
              j <= '0;
              if (g == g_max) state <= FLUSH;
              else            g     <= g + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (en) begin
        s1_vld  <= (state == RUN);
        s1_last <= (state == RUN) && is_last;
        s1_ar   <= f_ar;
        s1_ai   <= f_ai;
        s1_rneg <= f_rneg;
        s1_ineg <= f_ineg;
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
        s1_k    <= k;
`endif
      end
    end
  end

  // Table read data with sign applied.
  logic [DW-1:0] rd_r, rd_i, tw_r, tw_i;

  always_comb begin
    rd_r = rom[s1_ar];
    rd_i = rom[s1_ai];
    tw_r = s1_rneg ? -rd_r : rd_r;
    tw_i = s1_ineg ? -rd_i : rd_i;
  end

  // Stage 2: output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_tw    <= '0;
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
      out_k     <= '0;
`endif
    end else if (en) begin
      out_valid <= s1_vld;
      out_last  <= s1_vld && s1_last;
      if (s1_vld) begin
        out_tw <= {tw_r, tw_i};
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
        out_k  <= s1_k;
`endif
      end
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: directed bench for twiddle_seq (LOG2N=10) with a
// scoreboard of expected words built from real-valued cos/sin.
module tb_twiddle_seq;

  localparam int  LOG2N = 10;
  localparam int  DW    = 12;
  localparam int  N     = 1 << LOG2N;
  localparam int  HN    = N / 2;
  localparam real PI    = 3.141592653589793;

  logic          clk = 1'b0;
  logic          rst_n, start, inv, out_ready;
  logic [3:0]    stage;
  logic          out_valid, out_last, busy, stage_err;
  logic [2*DW-1:0] out_tw;
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
  logic [LOG2N-2:0] out_k;
`endif

  twiddle_seq #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stage     (stage),
    .inv       (inv),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_tw    (out_tw),
    .out_last  (out_last),
    .busy      (busy),
    .stage_err (stage_err)
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
    ,
    .out_k     (out_k)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tw;
    logic        last;
    logic [8:0]  k;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          acc_cnt = 0;
  logic [23:0] got [0:HN-1];
  logic        prev_stall = 1'b0;
  logic [23:0] prev_tw;
  logic        prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd_r(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  // Golden word straight from the trig definition of W_N^k.
  function automatic logic [23:0] model(input int k, input bit iv);
    real th;
    int  c, sn, ti;
    logic [11:0] cr, ci;
    th = 2.0 * PI * real'(k) / real'(N);
    c  = rnd_r(1024.0 * $cos(th));
    sn = rnd_r(1024.0 * $sin(th));
    ti = iv ? sn : -sn;
    cr = 12'(c);
    ci = 12'(ti);
    return {cr, ci};
  endfunction

  task automatic push_seq(input int s, input bit iv);
    int   span;
    exp_t e;
    span = N >> (s + 1);
    for (int gi = 0; gi < (1 << s); gi++)
      for (int ji = 0; ji < span; ji++) begin
        e.k    = 9'(ji << s);
        e.tw   = model(ji << s, iv);
        e.last = (gi == (1 << s) - 1) && (ji == span - 1);
        sb.push_back(e);
      end
  endtask

  // Output monitor: scoreboard pop on every accepted word, stall stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_tw", 32'(out_tw), 32'(prev_tw));
          check("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          tests++;
          assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL extra_word: got word %h expected no word", out_tw);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("word_tw", 32'(out_tw), 32'(e.tw));
            check("word_last", 32'(out_last), 32'(e.last));
`ifdef TWIDDLE_SEQ_IDX_OUT_EN
            check("word_k", 32'(out_k), 32'(e.k));
`endif
          end
          if (acc_cnt < HN) got[acc_cnt] = out_tw;
          acc_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_tw    = out_tw;
        prev_last  = out_last;
      end
    end
  end

  // One stage sequence. rnd: random out_ready; mid: extra start mid-RUN;
  // stop_at > 0: return once that many words have been accepted.
  task automatic run_seq(input int s, input bit iv, input bit rnd, input bit mid, input int stop_at);
    int c, first, lastc;
    acc_cnt = 0;
    push_seq(s, iv);
    @(posedge clk); #1;
    start = 1'b1; stage = 4'(s); inv = iv; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    c = 0; first = -1; lastc = -1;
    while (c < 5000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (mid && c == 50) begin start = 1'b1; stage = 4'd3; end
      else start = 1'b0;
      if (mid && c == 51) begin
        check("mid_start_err", 32'(stage_err), 32'd0);
        check("mid_start_busy", 32'(busy), 32'd1);
      end
      if (first < 0 && out_valid) first = c;
      if (lastc < 0 && out_valid && out_last) lastc = c;
      if (stop_at > 0 && acc_cnt >= stop_at) break;
      if (sb.size() == 0) break;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    check("first_word_cycle", 32'(first), 32'd2);
    if (stop_at == 0) begin
      check("seq_complete", 32'(sb.size()), 32'd0);
      check("word_count", 32'(acc_cnt), 32'(HN));
      check("busy_off", 32'(busy), 32'd0);
      check("valid_off", 32'(out_valid), 32'd0);
      if (!rnd) check("last_word_cycle", 32'(lastc), 32'(HN + 1));
    end
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = '0; inv = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_tw", 32'(out_tw), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(stage_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // stage 0, forward
    run_seq(0, 1'b0, 1'b0, 1'b0, 0);
    check("s0_w0", 32'(got[0]), 32'h400000);
    check("s0_w128", 32'(got[128]), 32'h2D4D2C);
    check("s0_w256", 32'(got[256]), 32'h000C00);
    check("s0_w384", 32'(got[384]), 32'hD2CD2C);

    // stage 9: every exponent is 0
    run_seq(9, 1'b0, 1'b0, 1'b0, 0);
    check("s9_w0", 32'(got[0]), 32'h400000);
    check("s9_w511", 32'(got[511]), 32'h400000);

    // stage 1, inverse
    run_seq(1, 1'b1, 1'b0, 1'b0, 0);
    check("s1i_w64", 32'(got[64]), 32'h2D42D4);
    check("s1i_w128", 32'(got[128]), 32'h000400);
    check("s1i_repeat", 32'(got[256]), 32'(got[0]));
    check("s1i_repeat64", 32'(got[320]), 32'h2D42D4);

    // stage 0 with random back-pressure
    run_seq(0, 1'b0, 1'b1, 1'b0, 0);

    // illegal stage
    @(posedge clk); #1;
    start = 1'b1; stage = 4'd12;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", 32'(stage_err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("err_single", 32'(stage_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("err_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // start re-asserted mid-RUN is ignored
    run_seq(0, 1'b0, 1'b0, 1'b1, 0);

    // asynchronous reset mid-sequence
    run_seq(0, 1'b0, 1'b0, 1'b0, 100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_tw", 32'(out_tw), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_seq(0, 1'b0, 1'b0, 1'b0, 0);
    check("post_rst_w0", 32'(got[0]), 32'h400000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Streaming twiddle-factor source for the radix-2 FFT datapath; drives the T operand of the complex multiplier.
- Emits W_N^k = cos(2πk/N) - j·sin(2πk/N) in the datapath's packed 24-bit complex format {Tr[23:12], Ti[11:0]}, in exact DIF stage order.
- Uses a quarter-wave cosine table with quadrant folding.
- Inverse mode emits conjugates for the IFFT.

Parameters:
- LOG2N, 10, log2 of FFT size N (N = 1024 default); legal range 3..12.
- DW, 12, width of each real/imag component; two's complement Q2.10, so 1.0 = 12'h400.
- ROM_FILE, "complex_mult/cos_q.txt", $readmemh image of cos(2πi/N) for i = 0..N/4 (N/4+1 words of DW bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a stage sequence; sampled only in IDLE.
- stage  in  4  DIF stage index s, sampled with start; legal 0..LOG2N-1.
- inv  in  1  1 = conjugate (IFFT) twiddles; sampled with start.
- out_ready  in  1  downstream accepts out_tw this cycle.
- out_valid  out  1  out_tw holds a valid twiddle.
- out_tw  out  2*DW  {Tr, Ti}.
- out_last  out  1  high with the final twiddle (N/2-th) of the sequence.
- busy  out  1  high from accepted start until the last word is accepted.
- stage_err  out  1  one-cycle pulse when start arrives with stage >= LOG2N.

Behaviour:
- Reset, asynchronous, any time including mid-sequence:
  - FSM goes to IDLE; all counters cleared.
  - out_valid = 0, out_tw = 0, out_last = 0, busy = 0, stage_err = 0.
- FSM states IDLE, RUN, FLUSH:
  - IDLE: start & stage < LOG2N -> RUN. Latches stage and inv, clears j (span index) and g (group index), sets busy.
  - IDLE: start & stage >= LOG2N -> stage_err = 1 for one cycle; stay in IDLE; busy stays 0.
  - RUN: issues one exponent per enabled cycle. After issuing the final exponent (g = 2^s - 1, j = span - 1) -> FLUSH.
  - FLUSH: pipeline drains. When the word with out_last is accepted (out_valid & out_ready) -> IDLE; busy drops the following cycle.
  - start in RUN or FLUSH is ignored and produces no error.
- Sequence for stage s:
  - span = N >> (s+1).
  - k = j << s, with j = 0..span-1 (inner loop), repeated for g = 0..2^s - 1 (outer loop).
  - Exactly N/2 words total.
- Pipeline: two stages with a common enable en = !out_valid | out_ready.
  - Stage 1: folded table address and quadrant/sign bits are registered.
  - Stage 2: synchronous table read, then sign/swap into the out_tw register.
  - Nothing advances when en = 0. out_tw, out_valid and out_last hold stable while out_valid & !out_ready.
- Latency and throughput:
  - start accepted at edge 0 -> out_valid high after edge 2 (first word visible in cycle 2).
  - With out_ready held high: one word per cycle; last word in cycle N/2 + 1.
- Quadrant fold, with k in [0, N/2) and cos_q[i] = table entry i:
  - k <= N/4: Tr = cos_q[k], Ti = -cos_q[N/4 - k].
  - k > N/4: Tr = -cos_q[N/2 - k], Ti = -cos_q[k - N/4].
  - inv = 1: Ti is negated after folding.
  - Table magnitudes are <= 12'h400, so negation never overflows.
  - The table needs two reads per word (real and imaginary). Implement as a dual-read ROM array.
- out_last is high only on the N/2-th word; out_valid is low on the cycle after it is accepted unless a new start has already been issued.
- A new start may be accepted in the first IDLE cycle; back-to-back sequences leave at most a 2-cycle bubble.

Optional Feature:
- Macro: TWIDDLE_SEQ_IDX_OUT_EN.
- Defined: adds output port out_k (LOG2N-1 bits) carrying the exponent k of the word on out_tw. It is pipelined in lockstep with out_tw, resets to 0, and holds during stalls.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- LOG2N=10, start stage=0 inv=0, out_ready=1:
  - word 0 = 24'h400000, word 128 = 24'h2D4D2C (cos45 = 0x2D4), word 256 = 24'h000C00, word 384 = 24'hD2CD2C.
  - out_last only on word 511; busy low 1 cycle after word 511 is accepted.
- stage=9, inv=0 -> 512 words all 24'h400000; out_last on word 511.
- stage=1, inv=1 -> word 64 (k=128) = 24'h2D42D4, word 128 (k=256) = 24'h000400; sequence repeats at word 256 (g=1).
- stage=0 with out_ready toggled by a random 50% pattern -> out_tw/out_valid stable during stalls; no word lost or duplicated; full sequence matches the Python golden table (out_k checked when TWIDDLE_SEQ_IDX_OUT_EN is defined).
- start with stage=12 -> stage_err pulses once, busy stays 0, no out_valid; start asserted again mid-RUN -> ignored, count still 512.
- rst_n pulled low at word 100, held 3 cycles, released -> all outputs 0 immediately; next start stage=0 produces word 0 = 24'h400000 in cycle 2.
